// File: rtl/multicycle_sequencer_pkg.sv
// Shared state encodings, opcode constants and opcode-class decode for the
// multicycle instruction sequencer.
package multicycle_sequencer_pkg;

  localparam logic [2:0] ST_IDLE   = 3'b000;
  localparam logic [2:0] ST_FETCH  = 3'b001;
  localparam logic [2:0] ST_DECODE = 3'b010;
  localparam logic [2:0] ST_EXEC   = 3'b011;
  localparam logic [2:0] ST_MEM    = 3'b100;
  localparam logic [2:0] ST_WB     = 3'b101;
  localparam logic [2:0] ST_HALT   = 3'b110;

  localparam logic [3:0] OP_LD  = 4'b1000;
  localparam logic [3:0] OP_ST  = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1011;
  localparam logic [3:0] OP_JZ  = 4'b1100;
  localparam logic [3:0] OP_JC  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_JUMP,
    CLS_NOP,
    CLS_HLT
  } op_class_e;

  // Opcodes 0000-0111 are all ALU; 1010 and 1110 fall through to NOP.
  function automatic op_class_e op_class(input logic [3:0] op);
    op_class_e cls;
    if (!op[3]) begin
      cls = CLS_ALU;
    end else begin
      case (op)
        OP_LD:                 cls = CLS_LD;
        OP_ST:                 cls = CLS_ST;
        OP_JMP, OP_JZ, OP_JC:  cls = CLS_JUMP;
        OP_HLT:                cls = CLS_HLT;
        default:               cls = CLS_NOP;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/sequencer_output_decode.sv
// Moore strobe decode: {state, registered opcode, flags} -> datapath and
// memory strobes. Purely combinational.
module sequencer_output_decode
  import multicycle_sequencer_pkg::*;
(
  input  logic [2:0] state_i,
  input  logic [3:0] opcode_q_i,
  input  logic       flag_z_i,
  input  logic       flag_c_i,
  output logic       ir_load_o,
  output logic       pc_inc_o,
  output logic       pc_load_o,
  output logic       rf_load_o,
  output logic       flag_load_o,
  output logic       ld_mux_s_o,
  output logic       st_mux_s_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       halted_o
);

  op_class_e cls;
  assign cls = op_class(opcode_q_i);

  always_comb begin
    ir_load_o   = 1'b0;
    pc_inc_o    = 1'b0;
    pc_load_o   = 1'b0;
    rf_load_o   = 1'b0;
    flag_load_o = 1'b0;
    ld_mux_s_o  = 1'b0;
    st_mux_s_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    halted_o    = 1'b0;
    case (state_i)
      ST_FETCH: begin
        ir_load_o = 1'b1;
        pc_inc_o  = 1'b1;
      end
      ST_EXEC: begin
        if (cls == CLS_ALU) begin
          rf_load_o   = 1'b1;
          flag_load_o = 1'b1;
        end
        pc_load_o = (opcode_q_i == OP_JMP) ||
                    ((opcode_q_i == OP_JZ) && flag_z_i) ||
                    ((opcode_q_i == OP_JC) && flag_c_i);
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        if (cls == CLS_ST) begin
          dmem_we_o  = 1'b1;
          st_mux_s_o = 1'b1;
        end
      end
      ST_WB: begin
        rf_load_o  = 1'b1;
        ld_mux_s_o = 1'b1;
      end
      ST_HALT: halted_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle CPU control sequencer: state register, latched opcode and a
// saturating retired-instruction counter; strobes come from the decode block.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic        flag_z,
  input  logic        flag_c,
  input  logic        dmem_ack,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        rf_load,
  output logic        flag_load,
  output logic        ld_mux_s,
  output logic        st_mux_s,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] instr_count
);

  logic [2:0]  state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [15:0] instr_count_q, instr_count_d;
  logic        retire;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        opcode_d = opcode;
        case (op_class(opcode))
          CLS_ALU, CLS_JUMP: state_d = ST_EXEC;
          CLS_LD, CLS_ST:    state_d = ST_MEM;
          CLS_NOP:           state_d = ST_FETCH;
          CLS_HLT:           state_d = ST_HALT;
          default:           state_d = ST_IDLE;
        endcase
      end
      ST_EXEC:   state_d = ST_FETCH;
      ST_MEM:    if (dmem_ack) state_d = (op_class(opcode_q) == CLS_LD) ? ST_WB : ST_FETCH;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // An instruction retires when control returns to FETCH from any execution
  // state, or when HLT commits into HALT.
  assign retire = ((state_d == ST_FETCH) &&
                   ((state_q == ST_DECODE) || (state_q == ST_EXEC) ||
                    (state_q == ST_MEM) || (state_q == ST_WB))) ||
                  ((state_q == ST_DECODE) && (state_d == ST_HALT));

  assign instr_count_d = (retire && (instr_count_q != 16'hFFFF)) ?
                         instr_count_q + 16'd1 : instr_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      opcode_q      <= 4'd0;
      instr_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign state       = state_q;
  assign instr_count = instr_count_q;

  sequencer_output_decode u_decode (
    .state_i     (state_q),
    .opcode_q_i  (opcode_q),
    .flag_z_i    (flag_z),
    .flag_c_i    (flag_c),
    .ir_load_o   (ir_load),
    .pc_inc_o    (pc_inc),
    .pc_load_o   (pc_load),
    .rf_load_o   (rf_load),
    .flag_load_o (flag_load),
    .ld_mux_s_o  (ld_mux_s),
    .st_mux_s_o  (st_mux_s),
    .dmem_req_o  (dmem_req),
    .dmem_we_o   (dmem_we),
    .halted_o    (halted)
  );

endmodule

// File: doc/multicycle_sequencer.md
MULTICYCLE_SEQUENCER -- requirements
Module: multicycle_sequencer

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces IDLE.
REQ-004 start  input  1  begins execution; honoured only in IDLE.
REQ-005 opcode  input  4  IR[15:12]; sampled only in DECODE.
REQ-006 flag_z, flag_c  input  1 each  zero and carry flags from the flag register.
REQ-007 dmem_ack  input  1  data memory completion; may be held low for any number of cycles.
REQ-008 ir_load, pc_inc, pc_load, rf_load, flag_load, ld_mux_s, st_mux_s  output  1 each  datapath strobes.
REQ-009 dmem_req, dmem_we  output  1 each  data memory request and write-enable.
REQ-010 halted  output  1  high while in HALT.
REQ-011 state  output  3  current state code.
REQ-012 instr_count  output  16  number of retired instructions.

Function
REQ-013 States and encodings SHALL be IDLE=000, FETCH=001, DECODE=010, EXEC=011, MEM=100, WB=101, HALT=110; code 111 SHALL go to IDLE on the next clock with all strobes low.
REQ-014 Opcode classes SHALL be: 0000-0111 ALU; 1000 LD; 1001 ST; 1011 JMP; 1100 JZ; 1101 JC; 1111 HLT; 1010 and 1110 NOP.
REQ-015 In DECODE the block SHALL register opcode into opcode_q; later states SHALL use only opcode_q.
REQ-016 Transitions:
- IDLE->FETCH on start=1.
- FETCH->DECODE always.
- DECODE->EXEC for ALU or jump class.
- DECODE->MEM for LD/ST.
- DECODE->FETCH for NOP.
- DECODE->HALT for HLT.
- EXEC->FETCH always.
- MEM stays while dmem_ack=0; on dmem_ack=1, LD->WB and ST->FETCH.
- WB->FETCH always.
- HALT holds until reset.
REQ-017 Strobes SHALL be Moore outputs decoded from state and opcode_q, and SHALL be 0 in every case not listed here:
- FETCH: ir_load=1, pc_inc=1.
- EXEC with ALU: rf_load=1, flag_load=1.
- EXEC with JMP, JZ with flag_z=1, or JC with flag_c=1: pc_load=1.
- MEM: dmem_req=1; additionally dmem_we=1 and st_mux_s=1 for ST.
- WB: rf_load=1, ld_mux_s=1.
REQ-018 dmem_req SHALL stay high, with dmem_we stable, from MEM entry until the cycle in which dmem_ack=1 is sampled.
REQ-019 A dmem_ack received outside MEM SHALL be ignored.
REQ-020 instr_count SHALL increment by 1 on each transition into FETCH from DECODE, EXEC, MEM or WB, and on DECODE->HALT.
REQ-021 instr_count SHALL saturate at 16'hFFFF.
REQ-022 start SHALL be ignored in every state except IDLE.
REQ-023 Latency: ALU and jump instructions SHALL take 3 cycles; ST SHALL take 3+w cycles and LD 4+w cycles, where w is the number of dmem_ack=0 cycles in MEM; NOP SHALL take 2 cycles.

Reset
REQ-024 Reset SHALL force, immediately and independent of clk: state=IDLE, opcode_q=0, instr_count=0, and all strobes plus halted low.
REQ-025 Reset during MEM SHALL drop dmem_req within the same cycle, and no ack SHALL be remembered.
REQ-026 After reset deassertion the block SHALL stay in IDLE until start=1.

Structure
REQ-027 A shared package SHALL hold the state encodings, the opcode constants and the opcode-class decode function.
REQ-028 One sub-module, sequencer_output_decode, SHALL hold the combinational decode {state, opcode_q, flags} -> strobes; the state register, opcode_q and the counter SHALL reside in the top module.

Verification
REQ-029 reset, start=1, opcode=0011 -> states 001,010,011,001; rf_load=1 and flag_load=1 in EXEC only; instr_count=1.
REQ-030 LD (1000) with dmem_ack low for 3 cycles -> dmem_req=1 and dmem_we=0 for 4 cycles in MEM; then WB with ld_mux_s=1 and rf_load=1; instr_count=1.
REQ-031 ST (1001) with dmem_ack=1 on the first MEM cycle -> dmem_we=1 and st_mux_s=1 for exactly 1 cycle; then FETCH; no WB.
REQ-032 JZ with flag_z=0, then JZ with flag_z=1 -> pc_load=0, then pc_load=1, each in EXEC.
REQ-033 HLT (1111) -> halted=1 permanently and start ignored; reset asserted mid-MEM -> state=000 and dmem_req=0 asynchronously.
REQ-034 Force instr_count to 16'hFFFE and retire 3 NOPs -> instr_count holds at 16'hFFFF.
